// File: rtl/slot_pkg.sv
// Shared types and constants for the three-reel slot controller.
package slot_pkg;

  localparam int SYMBOL_W  = 3;
  localparam int NUM_REELS = 3;

  typedef enum logic [2:0] {
    IDLE,
    SPIN,
    GAP1,
    GAP2,
    RESULT
  } state_t;

  // {win, pair} for three symbols; pair excludes the three-of-a-kind case
  function automatic logic [1:0] grade(
    input logic [SYMBOL_W-1:0] a,
    input logic [SYMBOL_W-1:0] b,
    input logic [SYMBOL_W-1:0] c
  );
    logic w;
    logic p;
    w = (a == b) && (b == c);
    p = !w && ((a == b) || (b == c) || (a == c));
    return {w, p};
  endfunction

endpackage

// File: rtl/reel_unit.sv
// One reel: advances while spinning, loads its stop symbol, then holds.
module reel_unit
  import slot_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                adv,
  input  logic                load,
  input  logic [SYMBOL_W-1:0] load_val,
  output logic [SYMBOL_W-1:0] sym
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sym <= '0;
    end else if (load) begin
      sym <= load_val;
    end else if (adv) begin
      sym <= sym + 1'b1;
    end
  end

endmodule

// File: rtl/reel_controller.sv
// Slot machine sequencer: spins three reels, stops them in turn,
// and grades the final symbols.
module reel_controller
  import slot_pkg::*;
#(
  parameter int SPIN_TICKS = 4,
  parameter int MIN_SPIN   = 32,
  parameter int STOP_GAP   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         rand_in,
  input  logic                start,
  output logic                busy,
  output logic [SYMBOL_W-1:0] reel0,
  output logic [SYMBOL_W-1:0] reel1,
  output logic [SYMBOL_W-1:0] reel2,
  output logic                done,
  output logic                win,
  output logic                pair
);

  localparam int PH_MAX = (MIN_SPIN > STOP_GAP) ? MIN_SPIN : STOP_GAP;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TK_W   = (SPIN_TICKS > 1) ? $clog2(SPIN_TICKS) : 1;

  localparam logic [PH_W-1:0] SPIN_LAST = PH_W'(MIN_SPIN - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(STOP_GAP - 1);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(SPIN_TICKS - 1);

  state_t state;
  state_t state_nx;

  logic [PH_W-1:0] phase;
  logic [TK_W-1:0] tick;

  logic                 accept;
  logic                 tick_end;
  logic                 spin_end;
  logic                 gap_end;
  logic [NUM_REELS-1:0] spinning;
  logic [NUM_REELS-1:0] load;
  logic [SYMBOL_W-1:0]  sym [NUM_REELS];
  logic                 unused_rand;

  assign accept      = (state == IDLE) && start;
  assign tick_end    = (tick == TICK_LAST);
  assign spin_end    = (phase == SPIN_LAST);
  assign gap_end     = (phase == GAP_LAST);
  assign unused_rand = ^rand_in[15:SYMBOL_W*NUM_REELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SPIN;
      SPIN:    if (spin_end) state_nx = GAP1;
      GAP1:    if (gap_end) state_nx = GAP2;
      GAP2:    if (gap_end) state_nx = RESULT;
      RESULT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    spinning = '0;
    load     = '0;
    unique case (state)
      SPIN: begin
        busy     = 1'b1;
        spinning = 3'b111;
        load[0]  = spin_end;
      end
      GAP1: begin
        busy     = 1'b1;
        spinning = 3'b110;
        load[1]  = gap_end;
      end
      GAP2: begin
        busy     = 1'b1;
        spinning = 3'b100;
        load[2]  = gap_end;
      end
      RESULT: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // phase restarts on every state change; tick free-runs while any reel spins
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      tick  <= '0;
    end else begin
      if (state_nx != state) begin
        phase <= '0;
      end else if (|spinning) begin
        phase <= phase + 1'b1;
      end
      if (accept) begin
        tick <= '0;
      end else if (|spinning) begin
        tick <= tick_end ? '0 : tick + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win  <= 1'b0;
      pair <= 1'b0;
    end else if (accept) begin
      win  <= 1'b0;
      pair <= 1'b0;
    end else if (load[2]) begin
      {win, pair} <= grade(sym[0], sym[1], rand_in[8:6]);
    end
  end

  for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
    reel_unit u_reel (
      .clk      (clk),
      .rst      (rst),
      .adv      (spinning[i] && tick_end),
      .load     (load[i]),
      .load_val (rand_in[SYMBOL_W*i +: SYMBOL_W]),
      .sym      (sym[i])
    );
  end

  assign reel0 = sym[0];
  assign reel1 = sym[1];
  assign reel2 = sym[2];

endmodule

// File: tb/tb_reel_controller.sv
// Scoreboard bench for reel_controller against a cycle-indexed
// arithmetic model of a spin.
module tb_reel_controller;

  localparam int ST  = 4;
  localparam int MS  = 32;
  localparam int SG  = 16;
  localparam int LAT = 1 + MS + 2 * SG;

  typedef struct {
    logic [2:0] r0;
    logic [2:0] r1;
    logic [2:0] r2;
    logic       busy;
    logic       done;
    logic       win;
    logic       pair;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rand_in = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [2:0]  reel0;
  logic [2:0]  reel1;
  logic [2:0]  reel2;
  logic        done;
  logic        win;
  logic        pair;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   held[3];
  logic m_win;
  logic m_pair;

  reel_controller #(
    .SPIN_TICKS (ST),
    .MIN_SPIN   (MS),
    .STOP_GAP   (SG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rand_in (rand_in),
    .start   (start),
    .busy    (busy),
    .reel0   (reel0),
    .reel1   (reel1),
    .reel2   (reel2),
    .done    (done),
    .win     (win),
    .pair    (pair)
  );

  always #5 clk = ~clk;

  function automatic exp_t idle_exp();
    exp_t e;
    e.r0   = 3'(held[0]);
    e.r1   = 3'(held[1]);
    e.r2   = 3'(held[2]);
    e.busy = 1'b0;
    e.done = 1'b0;
    e.win  = m_win;
    e.pair = m_pair;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.r0   = 3'd0;
    e.r1   = 3'd0;
    e.r2   = 3'd0;
    e.busy = 1'b0;
    e.done = 1'b0;
    e.win  = 1'b0;
    e.pair = 1'b0;
    return e;
  endfunction

  function automatic int fin(input logic [15:0] r, input int i);
    return int'((r >> (3 * i)) & 16'h7);
  endfunction

  // outputs k cycles after the start-accept cycle
  function automatic exp_t spin_exp(input int k, input logic [15:0] r);
    exp_t e;
    int   adv;
    int   stop_at[3];
    int   v[3];
    int   n;
    adv        = (k - 1) / ST;
    stop_at[0] = MS;
    stop_at[1] = MS + SG;
    stop_at[2] = MS + 2 * SG;
    for (int i = 0; i < 3; i++)
      v[i] = (k > stop_at[i]) ? fin(r, i) : (held[i] + adv) % 8;
    e.r0   = 3'(v[0]);
    e.r1   = 3'(v[1]);
    e.r2   = 3'(v[2]);
    e.busy = 1'b1;
    e.done = (k == LAT);
    n = int'(v[0] == v[1]) + int'(v[1] == v[2]) + int'(v[0] == v[2]);
    e.win  = e.done && (n == 3);
    e.pair = e.done && (n == 1);
    return e;
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    q.push_back(idle_exp());
  endtask

  // kcut < 0 runs the spin to completion; otherwise reset after k=kcut
  task automatic run_spin(input logic [15:0] r, input int kcut);
    int   last;
    exp_t e;
    last = (kcut < 0) ? LAT : kcut;
    @(posedge clk);
    #1;
    start   = 1'b1;
    rand_in = r;
    q.push_back(idle_exp());
    for (int k = 1; k <= last; k++)
      q.push_back(spin_exp(k, r));
    e = spin_exp(LAT, r);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      #1;
      start = (k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (kcut < 0) begin
      for (int i = 0; i < 3; i++) held[i] = fin(r, i);
      m_win  = e.win;
      m_pair = e.pair;
    end else begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.push_back(zero_exp());
      for (int i = 0; i < 3; i++) held[i] = 0;
      m_win  = 1'b0;
      m_pair = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (reel0 !== e.r0 || reel1 !== e.r1 || reel2 !== e.r2 ||
          busy !== e.busy || done !== e.done ||
          win !== e.win || pair !== e.pair) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got reels=%0d,%0d,%0d b=%0b d=%0b w=%0b p=%0b want reels=%0d,%0d,%0d b=%0b d=%0b w=%0b p=%0b",
                 $time, reel0, reel1, reel2, busy, done, win, pair,
                 e.r0, e.r1, e.r2, e.busy, e.done, e.win, e.pair);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) held[i] = 0;
    m_win  = 1'b0;
    m_pair = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back(zero_exp());
    idle_cycle();
    idle_cycle();
    run_spin(16'h0049, -1);
    idle_cycle();
    run_spin(16'h0009, -1);
    run_spin(16'h01C8, -1);
    idle_cycle();
    run_spin(16'($urandom), -1);
    run_spin(16'($urandom), 40);
    idle_cycle();
    run_spin(16'h0049, -1);
    for (int n = 0; n < 6; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) idle_cycle();
      run_spin(16'($urandom), -1);
    end
    idle_cycle();
    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reel_controller.md
REEL_CONTROLLER -- requirements
Module: reel_controller

Interface
REQ-001 SHALL have parameter SPIN_TICKS, default 4, clock cycles per symbol advance while a reel spins (>=1).
REQ-002 SHALL have parameter MIN_SPIN, default 32, cycles all three reels spin before the first stop (>=1).
REQ-003 SHALL have parameter STOP_GAP, default 16, cycles between successive reel stops (>=1).
REQ-004 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rand_in  input  16  free-running pseudo-random word from the LFSR.
REQ-007 SHALL have port start  input  1  spin request, sampled only in IDLE.
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance through the RESULT cycle.
REQ-009 SHALL have ports reel0, reel1, reel2  output  3 each  current symbol index (0..7) per reel.
REQ-010 SHALL have port done  output  1  one-cycle pulse, asserted in RESULT.
REQ-011 SHALL have port win  output  1  all three final symbols equal.
REQ-012 SHALL have port pair  output  1  exactly two final symbols equal (never together with win).

Function
REQ-013 SHALL implement FSM states IDLE, SPIN, GAP1, GAP2 and RESULT.
REQ-014 IDLE: start=1 -> SPIN next cycle; clear win/pair; clear phase and tick counters.
REQ-015 SHALL ignore start in every state other than IDLE; no queuing.
REQ-016 Tick counter SHALL count 0..SPIN_TICKS-1 and wrap; at SPIN_TICKS-1, every reel still spinning advances by +1 mod 8 (7->0).
REQ-017 Phase counter SHALL clear on each state entry and increment each cycle in SPIN, GAP1 and GAP2.
REQ-018 SPIN: at phase==MIN_SPIN-1, reel0 SHALL load rand_in[2:0] and freeze; go to GAP1.
REQ-019 GAP1: at phase==STOP_GAP-1, reel1 SHALL load rand_in[5:3] and freeze; go to GAP2.
REQ-020 GAP2: at phase==STOP_GAP-1, reel2 SHALL load rand_in[8:6] and freeze; go to RESULT.
REQ-021 A stop load SHALL take priority over a coincident tick advance for that reel.
REQ-022 Frozen reels SHALL hold their value until the next accepted start; reels then resume advancing from their held values.
REQ-023 RESULT: done=1 and win/pair valid for one cycle; go to IDLE; win/pair held until the next start acceptance.
REQ-024 Latency: start accepted at cycle T -> done at cycle T+1+MIN_SPIN+2*STOP_GAP; busy high over T+1 .. that cycle inclusive.
REQ-025 Counter widths SHALL be derived with $clog2 of the respective parameter; no truncation at maximum values.

Reset
REQ-026 rst SHALL take priority over all other inputs in any state, including mid-spin.
REQ-027 After reset: state IDLE, reel0/1/2=0, busy=0, done=0, win=0, pair=0, counters=0.

Structure
REQ-028 Package slot_pkg SHALL hold the FSM state enum, SYMBOL_W=3 and NUM_REELS=3.
REQ-029 SHALL use one sub-module, reel_unit (3-bit spin/load/hold register), instantiated three times; the FSM and counters reside in reel_controller.

Verification
REQ-030 Defaults, rand_in=16'h0049 held, start pulse at T -> done at T+65; reels 1,1,1; win=1, pair=0.
REQ-031 rand_in=16'h0009 -> reels 1,1,0; win=0, pair=1.
REQ-032 rand_in=16'h01C8 -> reels 0,1,7; win=0, pair=0.
REQ-033 During SPIN, a reel at 7 advances to 0 after SPIN_TICKS cycles; start pulses while busy=1 change nothing and done stays single.
REQ-034 rst asserted in GAP1 -> next cycle all outputs 0 and state IDLE; a following start gives a full-length spin (done 65 cycles later).
